// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Multi-cycle control FSM for the 8-bit data / 16-bit instruction datapath.
// A single memory port is shared between instruction fetch and data access,
// so each instruction is spread over fetch, decode, execute, memory and
// writeback states. Memory accesses handshake through mem_req/mem_ready and
// are bounded by a wait counter. If the counter expires, the sequencer traps
// into a sticky FAULT state. Illegal opcodes also trap into FAULT.
//
// Optional feature (macro SEQ_PERF_COUNTERS_EN): when the macro is defined,
// the outputs cyc_count and retired are added. cyc_count counts non-FAULT
// cycles and retired counts completed instructions. Both are CNT_W bits wide
// and wrap.
//
// Parameters:
//   WAIT_LIMIT : maximum consecutive cycles a memory state may wait for
//                mem_ready before FAULT. 0 disables the timeout.
//   CNT_W      : width of the optional performance counters.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   instr      in   instruction register: op=[15:13], funct=[1:0]
//   alu_flags  in   {N,Z,C,V} from the ALU in the current cycle
//   mem_ready  in   memory completes the access in this cycle
//   mem_req    out  memory access request
//   mem_write  out  write strobe; a write commits on mem_req && mem_ready
//   adr_src    out  0 = PC address, 1 = ALU result address
//   ir_write   out  load instruction register
//   pc_write   out  load PC
//   pc_src     out  0 = PC+1, 1 = branch target
//   reg_write  out  register file write enable
//   alu_src_b  out  0 = rd2, 1 = zero-extended imm
//   alu_ctrl   out  ALU operation
//   result_src out  0 = ALU result, 1 = memory read data
//   fault      out  sticky timeout / illegal-op indicator
//   state      out  current FSM state (debug)
//   cyc_count  out  (SEQ_PERF_COUNTERS_EN) non-FAULT cycle count
//   retired    out  (SEQ_PERF_COUNTERS_EN) retired instruction count
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic [3:0]        alu_flags,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_write,
    output logic              adr_src,
    output logic              ir_write,
    output logic              pc_write,
    output logic              pc_src,
    output logic              reg_write,
    output logic              alu_src_b,
    output logic [1:0]        alu_ctrl,
    output logic              result_src,
    output logic              fault,
    output logic [3:0]        state
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]  cyc_count,
    output logic [CNT_W-1:0]  retired
`endif
);

    typedef enum logic [3:0] {
        st_fetch   = 4'd0,
        st_decode  = 4'd1,
        st_exec_r  = 4'd2,
        st_exec_i  = 4'd3,
        st_alu_wb  = 4'd4,
        st_mem_adr = 4'd5,
        st_mem_rd  = 4'd6,
        st_mem_wb  = 4'd7,
        st_mem_wr  = 4'd8,
        st_branch  = 4'd9,
        st_fault   = 4'd15
    } state_t;

    // The wait counter only has to reach WAIT_LIMIT. With the timeout
    // disabled, it is one bit wide and wraps freely.
    localparam int WCW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(WAIT_LIMIT);

    generate
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("multicycle_sequencer: CNT_W must be at least 1");
        end
    endgenerate

    state_t          state_reg, state_next;
    logic [WCW-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [3:0]      flags_reg;

    logic [2:0]      op;
    logic [1:0]      funct;
    logic            mem_state;
    logic            timeout;

    assign op    = instr[15:13];
    assign funct = instr[1:0];
    assign state = state_reg;

    // Only Z takes part in sequencing. The other flag bits and the register
    // fields are consumed by the datapath, not here.
    logic unused_bits;
    assign unused_bits = ^{instr[12:2], flags_reg[3], flags_reg[1:0]};

    // FETCH, MEM_RD and MEM_WR are the only states that wait on memory.
    assign mem_state = (state_reg == st_fetch) || (state_reg == st_mem_rd) ||
                       (state_reg == st_mem_wr);

    // If mem_ready arrives in the limit cycle, the access completes instead of
    // trapping, because timeout is qualified with !mem_ready.
    assign timeout = (WAIT_LIMIT > 0) && mem_state && !mem_ready &&
                     (wait_cnt_reg == WAIT_MAX);

    // The counter clears on entry to a memory state, because every path into
    // one comes from a non-waiting cycle. It also clears on any ready cycle.
    assign wait_cnt_next = (mem_state && !mem_ready) ? (wait_cnt_reg + WCW'(1)) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= st_fetch;
            wait_cnt_reg <= '0;
            flags_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if ((state_reg == st_exec_r) || (state_reg == st_exec_i)) begin
                flags_reg <= alu_flags;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        alu_src_b  = 1'b0;
        alu_ctrl   = 2'b00;
        result_src = 1'b0;
        fault      = 1'b0;

        case (state_reg)
            st_fetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = st_decode;
                end else if (timeout) begin
                    state_next = st_fault;
                end
            end
            st_decode: begin
                case (op)
                    3'b000:         state_next = st_exec_r;
                    3'b001:         state_next = st_exec_i;
                    3'b010, 3'b011: state_next = st_mem_adr;
                    3'b100:         state_next = st_branch;
                    // BEQ uses the Z latched by the last ALU instruction.
                    3'b101:         state_next = flags_reg[2] ? st_branch : st_fetch;
                    default:        state_next = st_fault;
                endcase
            end
            st_exec_r: begin
                alu_ctrl   = funct;
                state_next = st_alu_wb;
            end
            st_exec_i: begin
                alu_src_b  = 1'b1;
                alu_ctrl   = funct;
                state_next = st_alu_wb;
            end
            st_alu_wb: begin
                reg_write  = 1'b1;
                state_next = st_fetch;
            end
            st_mem_adr: begin
                alu_src_b = 1'b1;
                case (op)
                    3'b010:  state_next = st_mem_rd;
                    3'b011:  state_next = st_mem_wr;
                    default: state_next = st_fault;
                endcase
            end
            st_mem_rd: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_next = st_mem_wb;
                end else if (timeout) begin
                    state_next = st_fault;
                end
            end
            st_mem_wb: begin
                reg_write  = 1'b1;
                result_src = 1'b1;
                state_next = st_fetch;
            end
            st_mem_wr: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_next = st_fetch;
                end else if (timeout) begin
                    state_next = st_fault;
                end
            end
            st_branch: begin
                alu_src_b  = 1'b1;
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                state_next = st_fetch;
            end
            st_fault: begin
                fault = 1'b1;
            end
            default: begin
                state_next = st_fault;
            end
        endcase

        // While reset is held, every strobe is forced low. This stops an
        // in-flight access at once, so a write cannot commit under reset.
        if (reset) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            reg_write  = 1'b0;
            alu_src_b  = 1'b0;
            alu_ctrl   = 2'b00;
            result_src = 1'b0;
            fault      = 1'b0;
        end
    end

`ifdef SEQ_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_count <= '0;
            retired   <= '0;
        end else begin
            if (state_reg != st_fault) begin
                cyc_count <= cyc_count + CNT_W'(1);
            end
            // Every completed instruction ends with a return to FETCH.
            if ((state_reg != st_fetch) && (state_next == st_fetch)) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Instruction-level reference model for multicycle_sequencer. Each
// instruction is expanded into the per-cycle list of states that it should
// visit. The expected strobes for each cycle come from the state table. The
// bench then replays the list against the DUT and compares the results.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam int TB_WAIT_LIMIT = 15;
    localparam int TB_CNT_W      = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = 16'h0000;
    logic [3:0]  alu_flags = 4'h0;
    logic        mem_ready = 1'b0;

    logic        mem_req, mem_write, adr_src, ir_write, pc_write, pc_src;
    logic        reg_write, alu_src_b, result_src, fault;
    logic [1:0]  alu_ctrl;
    logic [3:0]  state;
`ifdef SEQ_PERF_COUNTERS_EN
    logic [TB_CNT_W-1:0] cyc_count, retired;
`endif

    always #5 clk = ~clk;

    multicycle_sequencer #(
        .WAIT_LIMIT (TB_WAIT_LIMIT),
        .CNT_W      (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .alu_flags  (alu_flags),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .result_src (result_src),
        .fault      (fault),
        .state      (state)
`ifdef SEQ_PERF_COUNTERS_EN
        ,
        .cyc_count  (cyc_count),
        .retired    (retired)
`endif
    );

    // Output bundle: {mem_req, mem_write, adr_src, ir_write, pc_write, pc_src,
    //                 reg_write, alu_src_b, alu_ctrl[1:0], result_src, fault}
    logic [11:0] obs_out;
    assign obs_out = {mem_req, mem_write, adr_src, ir_write, pc_write, pc_src,
                      reg_write, alu_src_b, alu_ctrl, result_src, fault};

    int checks = 0;
    int errors = 0;

    // Writes actually committed by the DUT (request + write + ready at an edge).
    int commits = 0;
    always @(posedge clk) begin
        if (mem_req && mem_write && mem_ready) commits++;
    end

    // Reference model state.
    logic m_z = 1'b0;
    int   m_cyc = 0;
    int   m_ret = 0;
    int   m_commits = 0;

    // Stimulus / expectation trace, one entry per clock cycle.
    logic [15:0] q_instr[$];
    logic        q_ready[$];
    logic [3:0]  q_flags[$];
    logic [3:0]  q_state[$];
    logic [11:0] q_out[$];
    int          q_cyc[$];
    int          q_ret[$];
    logic [3:0]  o_state[$];
    logic [11:0] o_out[$];
    int          o_cyc[$];
    int          o_ret[$];

    // Expected strobes for a state, taken from the state table.
    function automatic logic [11:0] spec_out(logic [3:0] st, logic rdy, logic [1:0] fn);
        logic req, wr, adr, irw, pcw, pcs, rw, srcb, res, flt;
        logic [1:0] ctrl;
        {req, wr, adr, irw, pcw, pcs, rw, srcb, res, flt} = '0;
        ctrl = 2'b00;
        case (st)
            4'd0:  begin req = 1; if (rdy) begin irw = 1; pcw = 1; end end
            4'd2:  ctrl = fn;
            4'd3:  begin srcb = 1; ctrl = fn; end
            4'd4:  rw = 1;
            4'd5:  srcb = 1;
            4'd6:  begin req = 1; adr = 1; end
            4'd7:  begin rw = 1; res = 1; end
            4'd8:  begin req = 1; adr = 1; wr = 1; end
            4'd9:  begin srcb = 1; pcw = 1; pcs = 1; end
            4'd15: flt = 1;
            default: ;
        endcase
        return {req, wr, adr, irw, pcw, pcs, rw, srcb, ctrl, res, flt};
    endfunction

    task automatic clear_trace();
        q_instr.delete(); q_ready.delete(); q_flags.delete(); q_state.delete();
        q_out.delete(); q_cyc.delete(); q_ret.delete();
    endtask

    task automatic model_reset();
        m_z = 1'b0; m_cyc = 0; m_ret = 0;
    endtask

    task automatic add_cycle(logic [15:0] ins, logic [3:0] st, logic rdy, logic [3:0] fl);
        q_instr.push_back(ins);
        q_ready.push_back(rdy);
        q_flags.push_back(fl);
        q_state.push_back(st);
        q_out.push_back(spec_out(st, rdy, ins[1:0]));
        q_cyc.push_back(m_cyc);
        q_ret.push_back(m_ret);
        if (st != 4'd15) m_cyc++;
    endtask

    // Expand one legal instruction into its expected cycle list.
    // fw / mw: cycles of mem_ready=0 before ready in fetch / data access.
    task automatic add_instr(logic [15:0] ins, int fw, int mw, logic [3:0] ex_flags);
        logic [2:0] op;
        op = ins[15:13];
        for (int i = 0; i < fw; i++) add_cycle(ins, 4'd0, 1'b0, 4'($urandom));
        add_cycle(ins, 4'd0, 1'b1, 4'($urandom));
        add_cycle(ins, 4'd1, 1'($urandom), 4'($urandom));
        case (op)
            3'd0, 3'd1: begin
                add_cycle(ins, (op == 3'd0) ? 4'd2 : 4'd3, 1'($urandom), ex_flags);
                m_z = ex_flags[2];
                add_cycle(ins, 4'd4, 1'($urandom), 4'($urandom));
            end
            3'd2: begin
                add_cycle(ins, 4'd5, 1'($urandom), 4'($urandom));
                for (int i = 0; i < mw; i++) add_cycle(ins, 4'd6, 1'b0, 4'($urandom));
                add_cycle(ins, 4'd6, 1'b1, 4'($urandom));
                add_cycle(ins, 4'd7, 1'($urandom), 4'($urandom));
            end
            3'd3: begin
                add_cycle(ins, 4'd5, 1'($urandom), 4'($urandom));
                for (int i = 0; i < mw; i++) add_cycle(ins, 4'd8, 1'b0, 4'($urandom));
                add_cycle(ins, 4'd8, 1'b1, 4'($urandom));
                m_commits++;
            end
            3'd4: add_cycle(ins, 4'd9, 1'($urandom), 4'($urandom));
            3'd5: if (m_z) add_cycle(ins, 4'd9, 1'($urandom), 4'($urandom));
            default: ;
        endcase
        m_ret++;
    endtask

    // Drive the trace and record the DUT response (sampled 1ns after the drive,
    // mid low phase).
    task automatic play();
        o_state.delete(); o_out.delete(); o_cyc.delete(); o_ret.delete();
        for (int i = 0; i < q_state.size(); i++) begin
            instr     = q_instr[i];
            mem_ready = q_ready[i];
            alu_flags = q_flags[i];
            #1;
            o_state.push_back(state);
            o_out.push_back(obs_out);
`ifdef SEQ_PERF_COUNTERS_EN
            o_cyc.push_back(int'(cyc_count));
            o_ret.push_back(int'(retired));
`endif
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        instr = 16'($urandom);
        alu_flags = 4'($urandom);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d, expected 0", state);
        end
        checks++;
        if (obs_out !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected %b", obs_out, 12'h000);
        end
`ifdef SEQ_PERF_COUNTERS_EN
        checks++;
        if (cyc_count !== '0 || retired !== '0) begin
            errors++;
            $display("FAIL reset_counters: got cyc=%0d ret=%0d, expected 0 0", cyc_count, retired);
        end
`endif
        reset = 1'b0;
        model_reset();
        $display("test_reset: done");
    endtask

    task automatic test_alu_basic();
        clear_trace();
        add_instr(16'h0401, 0, 0, 4'h0);
        play();
        for (int i = 0; i < q_state.size(); i++) begin
            checks++;
            if (o_state[i] !== q_state[i] || o_out[i] !== q_out[i]) begin
                errors++;
                $display("FAIL alu_basic cycle %0d: got state=%0d out=%b, expected state=%0d out=%b",
                         i, o_state[i], o_out[i], q_state[i], q_out[i]);
            end
        end
        $display("test_alu_basic: instr=0401 cycles=%0d", q_state.size());
    endtask

    task automatic test_ldr();
        int n;
        clear_trace();
        add_instr(16'h4485, 0, 3, 4'h0);
        play();
        for (int i = 0; i < q_state.size(); i++) begin
            checks++;
            if (o_state[i] !== q_state[i] || o_out[i] !== q_out[i]) begin
                errors++;
                $display("FAIL ldr cycle %0d: got state=%0d out=%b, expected state=%0d out=%b",
                         i, o_state[i], o_out[i], q_state[i], q_out[i]);
            end
        end
        // Data-phase request with the ALU address must be held for 3 wait + 1 ready cycles.
        n = 0;
        for (int i = 0; i < o_out.size(); i++) if (o_out[i][11] && o_out[i][9]) n++;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL ldr_req_len: got %0d cycles, expected 4", n);
        end
        $display("test_ldr: instr=4485 cycles=%0d", q_state.size());
    endtask

    task automatic test_beq();
        logic [3:0] fl;
        for (int pass = 0; pass < 2; pass++) begin
            clear_trace();
            fl = (pass == 0) ? 4'b0100 : 4'b1011;
            add_instr({3'b000, 13'($urandom)}, 0, 0, fl);
            add_instr(16'h4485, 0, $urandom_range(0, 2), 4'h0);
            add_instr(16'hA000, 0, 0, 4'h0);
            // Outside the execute states, drive the opposite Z so that any
            // stray latch becomes visible.
            for (int i = 0; i < q_flags.size(); i++)
                if (q_state[i] != 4'd2 && q_state[i] != 4'd3) q_flags[i] = fl ^ 4'b0100;
            play();
            for (int i = 0; i < q_state.size(); i++) begin
                checks++;
                if (o_state[i] !== q_state[i] || o_out[i] !== q_out[i]) begin
                    errors++;
                    $display("FAIL beq pass %0d cycle %0d: got state=%0d out=%b, expected state=%0d out=%b",
                             pass, i, o_state[i], o_out[i], q_state[i], q_out[i]);
                end
            end
            $display("test_beq: z=%0d taken=%0d", fl[2], q_state[q_state.size()-1] == 4'd9);
        end
    endtask

    task automatic test_random();
        int n_instr = 40;
        logic [15:0] ins;
        clear_trace();
        for (int k = 0; k < n_instr; k++) begin
            ins = {3'($urandom_range(0, 5)), 13'($urandom)};
            add_instr(ins, $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0) ? TB_WAIT_LIMIT : $urandom_range(0, 3),
                      4'($urandom));
        end
        play();
        for (int i = 0; i < q_state.size(); i++) begin
            checks++;
            if (o_state[i] !== q_state[i] || o_out[i] !== q_out[i]) begin
                errors++;
                $display("FAIL random cycle %0d: got state=%0d out=%b, expected state=%0d out=%b",
                         i, o_state[i], o_out[i], q_state[i], q_out[i]);
            end
        end
        checks++;
        if (commits != m_commits) begin
            errors++;
            $display("FAIL random_commits: got %0d, expected %0d", commits, m_commits);
        end
        $display("test_random: instrs=%0d cycles=%0d writes=%0d", n_instr, q_state.size(), m_commits);
    endtask

    task automatic test_wait_limit();
        clear_trace();
        add_instr(16'h4485, TB_WAIT_LIMIT, TB_WAIT_LIMIT, 4'h0);
        add_instr({3'b011, 13'($urandom)}, 0, TB_WAIT_LIMIT, 4'h0);
        play();
        for (int i = 0; i < q_state.size(); i++) begin
            checks++;
            if (o_state[i] !== q_state[i] || o_out[i] !== q_out[i]) begin
                errors++;
                $display("FAIL wait_limit cycle %0d: got state=%0d out=%b, expected state=%0d out=%b",
                         i, o_state[i], o_out[i], q_state[i], q_out[i]);
            end
        end
        $display("test_wait_limit: waits=%0d cycles=%0d", TB_WAIT_LIMIT, q_state.size());
    endtask

    task automatic test_timeout();
        logic [15:0] ins;
        int commits_before;
        commits_before = commits;
        ins = {3'b011, 13'($urandom)};
        clear_trace();
        add_cycle(ins, 4'd0, 1'b1, 4'h0);
        add_cycle(ins, 4'd1, 1'b0, 4'h0);
        add_cycle(ins, 4'd5, 1'b0, 4'h0);
        for (int i = 0; i <= TB_WAIT_LIMIT; i++) add_cycle(ins, 4'd8, 1'b0, 4'($urandom));
        for (int i = 0; i < 4; i++) add_cycle(ins, 4'd15, 1'($urandom), 4'($urandom));
        play();
        for (int i = 0; i < q_state.size(); i++) begin
            checks++;
            if (o_state[i] !== q_state[i] || o_out[i] !== q_out[i]) begin
                errors++;
                $display("FAIL timeout cycle %0d: got state=%0d out=%b, expected state=%0d out=%b",
                         i, o_state[i], o_out[i], q_state[i], q_out[i]);
            end
        end
        checks++;
        if (commits != commits_before) begin
            errors++;
            $display("FAIL timeout_commits: got %0d, expected %0d", commits, commits_before);
        end
        do_reset();
        #1;
        checks++;
        if (state !== 4'd0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got state=%0d fault=%b, expected 0 0", state, fault);
        end
        $display("test_timeout: fault after %0d wait cycles, cleared by reset", TB_WAIT_LIMIT + 1);
    endtask

    task automatic test_illegal();
        logic [15:0] ins;
        ins = {3'b111, 13'($urandom)};
        clear_trace();
        add_cycle(ins, 4'd0, 1'b1, 4'h0);
        add_cycle(ins, 4'd1, 1'($urandom), 4'h0);
        for (int i = 0; i < 3; i++) add_cycle(ins, 4'd15, 1'($urandom), 4'($urandom));
        play();
        for (int i = 0; i < q_state.size(); i++) begin
            checks++;
            if (o_state[i] !== q_state[i] || o_out[i] !== q_out[i]) begin
                errors++;
                $display("FAIL illegal cycle %0d: got state=%0d out=%b, expected state=%0d out=%b",
                         i, o_state[i], o_out[i], q_state[i], q_out[i]);
            end
        end
        do_reset();
        $display("test_illegal: instr=%h", ins);
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] ins;
        int commits_before;
        ins = {3'b011, 13'($urandom)};
        commits_before = commits;
        clear_trace();
        add_cycle(ins, 4'd0, 1'b1, 4'h0);
        add_cycle(ins, 4'd1, 1'b0, 4'h0);
        add_cycle(ins, 4'd5, 1'b0, 4'h0);
        add_cycle(ins, 4'd8, 1'b0, 4'h0);
        add_cycle(ins, 4'd8, 1'b0, 4'h0);
        play();
        for (int i = 0; i < q_state.size(); i++) begin
            checks++;
            if (o_state[i] !== q_state[i] || o_out[i] !== q_out[i]) begin
                errors++;
                $display("FAIL mid_write cycle %0d: got state=%0d out=%b, expected state=%0d out=%b",
                         i, o_state[i], o_out[i], q_state[i], q_out[i]);
            end
        end
        // Raise ready and reset together in the middle of the write.
        mem_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || mem_write !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL mid_write_abort: got state=%0d mem_req=%b mem_write=%b, expected 0 0 0",
                     state, mem_req, mem_write);
        end
        @(posedge clk);
        #1;
        checks++;
        if (commits != commits_before) begin
            errors++;
            $display("FAIL mid_write_commit: got %0d writes, expected %0d", commits, commits_before);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        $display("test_reset_mid_write: aborted write, commits=%0d", commits);
    endtask

`ifdef SEQ_PERF_COUNTERS_EN
    task automatic test_perf();
        int modv;
        modv = 1 << TB_CNT_W;
        do_reset();
        clear_trace();
        for (int k = 0; k < 5; k++)
            add_instr({3'($urandom_range(0, 1)), 13'($urandom)}, 0, 0, 4'($urandom));
        for (int i = 0; i < q_ready.size(); i++) q_ready[i] = 1'b1;
        play();
        for (int i = 0; i < q_state.size(); i++) begin
            checks++;
            if (o_state[i] !== q_state[i] || o_cyc[i] != (q_cyc[i] % modv) ||
                o_ret[i] != (q_ret[i] % modv)) begin
                errors++;
                $display("FAIL perf cycle %0d: got state=%0d cyc=%0d ret=%0d, expected state=%0d cyc=%0d ret=%0d",
                         i, o_state[i], o_cyc[i], o_ret[i], q_state[i], q_cyc[i] % modv, q_ret[i] % modv);
            end
        end
        #1;
        checks++;
        if (int'(cyc_count) != (m_cyc % modv) || int'(retired) != (m_ret % modv)) begin
            errors++;
            $display("FAIL perf_final: got cyc=%0d ret=%0d, expected cyc=%0d ret=%0d",
                     cyc_count, retired, m_cyc % modv, m_ret % modv);
        end
        $display("test_perf: cycles=%0d cyc_count=%0d retired=%0d", m_cyc, cyc_count, retired);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_basic();
        test_ldr();
        test_beq();
        test_random();
        test_wait_limit();
        test_timeout();
        test_illegal();
        test_reset_mid_write();
`ifdef SEQ_PERF_COUNTERS_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit data / 16-bit instruction datapath (register file, ALU, data memory, PC mux).
- Replaces the single-cycle control decode.
- Sequences fetch, decode, execute, memory and writeback over several clocks, so one memory port serves both instruction fetch and data access.
- Handshakes with that memory port through mem_req/mem_ready. Latches ALU flags for conditional branches. Traps on memory timeout.

Parameters:
- WAIT_LIMIT, 15: max consecutive cycles a memory state may wait for mem_ready before FAULT. 0 disables the timeout.
- CNT_W, 16: width of the optional performance counters.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr  in  16  instruction register contents: op=[15:13], rd=[12:10], rn=[9:7], rm=[6:4], imm=[5:0], funct=[1:0]
- alu_flags  in  4  {N,Z,C,V} from the ALU, current cycle
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  write strobe; qualified by mem_req && mem_ready
- adr_src  out  1  0 = PC address, 1 = ALU result address
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  1  0 = PC+1, 1 = branch target (ALU result)
- reg_write  out  1  register file write enable
- alu_src_b  out  1  0 = rd2, 1 = zero-extended imm
- alu_ctrl  out  2  ALU operation
- result_src  out  1  0 = ALU result, 1 = memory read data
- fault  out  1  sticky timeout / illegal-op indicator
- state  out  4  current FSM state, for debug

Behaviour:
- Reset (async, immediate):
  - State goes to FETCH.
  - All outputs go to 0, including fault, flag register and wait counter.
  - The first rising edge after reset deassertion is spent in FETCH.
  - Reset mid-access aborts the access; no write completes.
- Opcodes:
  - 000 = ALU register
  - 001 = ALU immediate
  - 010 = LDR
  - 011 = STR
  - 100 = B
  - 101 = BEQ
  - 110/111 = illegal
- States and encodings (Moore outputs except the mem_ready-qualified strobes):
  - FETCH (0):
    - Outputs: mem_req=1, adr_src=0.
    - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE. Otherwise stay.
  - DECODE (1): one cycle, dispatch on op.
    - 000 → EXEC_R
    - 001 → EXEC_I
    - 010/011 → MEM_ADR
    - 100 → BRANCH
    - 101 → BRANCH if latched Z=1, else FETCH
    - 11x → FAULT
  - EXEC_R (2): alu_src_b=0, alu_ctrl=funct; latch alu_flags into the flag register; → ALU_WB.
  - EXEC_I (3): alu_src_b=1, alu_ctrl=funct; latch alu_flags; → ALU_WB.
  - ALU_WB (4): reg_write=1, result_src=0; → FETCH.
  - MEM_ADR (5): alu_src_b=1, alu_ctrl=00 (add); → MEM_RD if op=010, MEM_WR if op=011.
  - MEM_RD (6): mem_req=1, adr_src=1; on mem_ready → MEM_WB.
  - MEM_WB (7): reg_write=1, result_src=1; → FETCH.
  - MEM_WR (8):
    - Outputs: mem_req=1, adr_src=1, mem_write=1.
    - On mem_ready → FETCH. The write is committed exactly once, in the ready cycle.
  - BRANCH (9): alu_src_b=1, alu_ctrl=00, pc_write=1, pc_src=1; → FETCH.
  - FAULT (15): fault=1, all strobes 0. Terminal until reset.
- Flag register: updates only in EXEC_R/EXEC_I. LDR, STR and branches leave it unchanged.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR, and whenever mem_ready=1.
  - Increments each cycle spent in those states with mem_ready=0.
  - If WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT with mem_ready still 0 → FAULT on the next edge.
  - mem_ready in the same cycle the limit is reached wins: the access completes and no fault is raised.
- mem_ready outside a memory state is ignored.
- Cycle counts with mem_ready tied high:
  - ALU ops: 4
  - LDR: 5
  - STR: 4
  - B: 3
  - BEQ not taken: 2

Optional Feature:
- Macro: SEQ_PERF_COUNTERS_EN.
- When defined, adds two outputs:
  - cyc_count[CNT_W-1:0]: increments every cycle out of reset, excluding FAULT.
  - retired[CNT_W-1:0]: increments on each transition into FETCH from a non-FETCH state.
  - Both cleared by reset; both wrap modulo 2^CNT_W.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Reset held, then released with mem_ready=1 and instr=0x0401 (op 000) → state sequence 0,1,2,4,0. ir_write and pc_write both 1 in the FETCH cycle. alu_ctrl=01 in EXEC_R. reg_write=1 only in ALU_WB.
- LDR instr=0x4485, mem_ready low for 3 cycles in MEM_RD then high → mem_req/adr_src=1 held for 4 cycles. MEM_WB asserts reg_write=1, result_src=1. No fault.
- STR with mem_ready stuck 0, WAIT_LIMIT=15 → FAULT entered 16 cycles after MEM_WR entry. fault=1 sticky, mem_write=0 thereafter. Asserting reset clears it to FETCH.
- ALU op producing Z=1, then BEQ (op 101) → BRANCH with pc_write=1, pc_src=1. Repeat after an op producing Z=0 → DECODE returns to FETCH, no pc_write. An intervening LDR does not alter the latched Z.
- Opcode 111 → FAULT after DECODE. Separately, async reset asserted mid-MEM_WR before mem_ready → immediate FETCH with mem_write=0, no write cycle.
- With SEQ_PERF_COUNTERS_EN, CNT_W=4: run 5 ALU instructions with mem_ready=1 → cyc_count wraps from 15 to 0 and reads 4 after 20 cycles; retired=5.
